// File: rtl/lpc_sample_reconstructor_pkg.sv
// Shared FLAC parameter header for the LPC encoder/decoder blocks.
// Holds the default order, block size and datapath widths, plus the
// reconstructor FSM state encoding.
package lpc_sample_reconstructor_pkg;

  localparam int LPC_MAX_ORDER    = 12;
  localparam int LPC_BLOCK_SIZE   = 4096;
  localparam int LPC_COEF_WIDTH   = 15;
  localparam int LPC_SAMPLE_WIDTH = 16;
  localparam int LPC_RES_WIDTH    = 24;
  localparam int LPC_ACC_WIDTH    = 40;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_RUN    = 3'd2,
    ST_MAC    = 3'd3,
    ST_EMIT   = 3'd4,
    ST_DONE   = 3'd5
  } lpc_state_t;

endpackage

// File: rtl/lpc_sample_reconstructor_mac.sv
// lpc_mac: signed multiply-accumulate for the LPC predictor.
// Ports:
//   iClock, iReset (async, active-low)
//   clear   - zero the accumulator (has priority over enable)
//   enable  - add coef*sample into the accumulator this cycle
//   coef    - signed quantized coefficient
//   sample  - signed history sample
//   acc     - signed ACC_WIDTH accumulator
module lpc_mac
  import lpc_sample_reconstructor_pkg::*;
#(
  parameter int COEF_WIDTH   = LPC_COEF_WIDTH,
  parameter int SAMPLE_WIDTH = LPC_SAMPLE_WIDTH,
  parameter int ACC_WIDTH    = LPC_ACC_WIDTH
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [COEF_WIDTH-1:0]   coef,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic [ACC_WIDTH-1:0]    acc
);

  localparam int PROD_W = COEF_WIDTH + SAMPLE_WIDTH;

  logic signed [PROD_W-1:0]    prod_p0;
  logic signed [ACC_WIDTH-1:0] acc_p1;

  assign prod_p0 = $signed(coef) * $signed(sample);

  // ---- stage p0 -> p1: accumulate ----
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      acc_p1 <= '0;
    end else if (clear) begin
      acc_p1 <= '0;
    end else if (enable) begin
      acc_p1 <= acc_p1 + ACC_WIDTH'(prod_p0);
    end
  end

  assign acc = acc_p1;

endmodule

// File: rtl/lpc_sample_reconstructor.sv
// lpc_sample_reconstructor: rebuilds FLAC LPC samples from warm-up samples
// and residuals. The first ORDER words of a block pass through verbatim;
// each later residual is added to the shifted prediction
// sum(coef[j]*hist[j]), computed one tap per cycle.
// Ports:
//   iClock, iReset (async, active-low), iEnable (clock enable)
//   iCoefWrite/iCoefAddr/iCoef - coefficient load (IDLE/DONE only)
//   iStart/iOrder/iShift       - block start, latches order and shift
//   iValid/iResidual/oReady    - input word handshake
//   oSample/oValid             - reconstructed sample, one-cycle pulse
//   oDone                      - block complete, held until next iStart
//   oError                     - sticky, illegal order requested
module lpc_sample_reconstructor
  import lpc_sample_reconstructor_pkg::*;
#(
  parameter int MAX_ORDER    = LPC_MAX_ORDER,
  parameter int BLOCK_SIZE   = LPC_BLOCK_SIZE,
  parameter int COEF_WIDTH   = LPC_COEF_WIDTH,
  parameter int SAMPLE_WIDTH = LPC_SAMPLE_WIDTH,
  parameter int RES_WIDTH    = LPC_RES_WIDTH
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    iEnable,
  input  logic                    iCoefWrite,
  input  logic [3:0]              iCoefAddr,
  input  logic [COEF_WIDTH-1:0]   iCoef,
  input  logic                    iStart,
  input  logic [3:0]              iOrder,
  input  logic [4:0]              iShift,
  input  logic                    iValid,
  input  logic [RES_WIDTH-1:0]    iResidual,
  output logic                    oReady,
  output logic [SAMPLE_WIDTH-1:0] oSample,
  output logic                    oValid,
  output logic                    oDone,
  output logic                    oError
);

  localparam int ACC_WIDTH = LPC_ACC_WIDTH;
  localparam int CNT_W     = $clog2(BLOCK_SIZE + 1);
  localparam logic [3:0]       MAX_ORDER_L = 4'(MAX_ORDER);
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(BLOCK_SIZE - 1);

  lpc_state_t state_q, state_d;

  logic signed [COEF_WIDTH-1:0]   coef_q [MAX_ORDER];
  logic signed [SAMPLE_WIDTH-1:0] hist_q [MAX_ORDER];
  logic [3:0]                     order_q;
  logic [4:0]                     shift_q;
  logic [3:0]                     tap_q;
  logic [CNT_W-1:0]               cnt_q;
  logic signed [RES_WIDTH-1:0]    res_p0;
  logic signed [SAMPLE_WIDTH-1:0] sample_q;
  logic                           warm_vld_p1;
  logic                           err_q;
  logic [ACC_WIDTH-1:0]           acc_p1;

  logic                           idle_like;
  logic                           start_ok;
  logic                           start_bad;
  logic                           accept;
  logic                           last_tap;
  logic                           last_out;
  logic                           coef_wr;
  logic                           push_en;
  logic signed [SAMPLE_WIDTH-1:0] push_val;
  logic signed [SAMPLE_WIDTH-1:0] emit_val;

  // residual + (acc >>> shift), wrapped to the sample width.
  function automatic logic signed [SAMPLE_WIDTH-1:0] emit_sample(
    input logic signed [RES_WIDTH-1:0] res,
    input logic signed [ACC_WIDTH-1:0] acc,
    input logic [4:0]                  sh
  );
    logic signed [ACC_WIDTH:0] sum;
    sum = (ACC_WIDTH+1)'(res) + (ACC_WIDTH+1)'(acc >>> sh);
    return sum[SAMPLE_WIDTH-1:0];
  endfunction

  // Warm-up words are passed through, keeping only the sample-width bits.
  function automatic logic signed [SAMPLE_WIDTH-1:0] trunc_sample(
    input logic [RES_WIDTH-1:0] w
  );
    return w[SAMPLE_WIDTH-1:0];
  endfunction

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_ok  = iEnable && idle_like && iStart && (iOrder <= MAX_ORDER_L);
  assign start_bad = iEnable && idle_like && iStart && (iOrder > MAX_ORDER_L);
  assign coef_wr   = iEnable && idle_like && iCoefWrite && (iCoefAddr < MAX_ORDER_L);
  assign oReady    = iEnable && ((state_q == ST_WARMUP) || (state_q == ST_RUN));
  assign accept    = iValid && oReady;
  assign last_tap  = (tap_q == order_q - 4'd1);
  assign last_out  = (cnt_q == LAST_CNT);
  assign emit_val  = emit_sample(res_p0, $signed(acc_p1), shift_q);

  assign push_en  = (accept && (state_q == ST_WARMUP)) ||
                    (iEnable && (state_q == ST_EMIT));
  assign push_val = (state_q == ST_EMIT) ? emit_val : trunc_sample(iResidual);

  assign oSample = (state_q == ST_EMIT) ? emit_val : sample_q;
  assign oValid  = iEnable && ((state_q == ST_EMIT) || warm_vld_p1);
  assign oDone   = (state_q == ST_DONE);
  assign oError  = err_q;

  lpc_mac #(
    .COEF_WIDTH  (COEF_WIDTH),
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_mac (
    .iClock (iClock),
    .iReset (iReset),
    .clear  (accept && (state_q == ST_RUN)),
    .enable (iEnable && (state_q == ST_MAC)),
    .coef   (coef_q[tap_q]),
    .sample (hist_q[tap_q]),
    .acc    (acc_p1)
  );

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (iEnable) begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_bad)    state_d = ST_IDLE;
          else if (start_ok) state_d = (iOrder == 4'd0) ? ST_RUN : ST_WARMUP;
        end
        ST_WARMUP: begin
          if (iValid) begin
            if (last_out)      state_d = ST_DONE;
            else if (last_tap) state_d = ST_RUN;
          end
        end
        ST_RUN:  if (iValid) state_d = (order_q == 4'd0) ? ST_EMIT : ST_MAC;
        ST_MAC:  if (last_tap) state_d = ST_EMIT;
        ST_EMIT: state_d = last_out ? ST_DONE : ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---- stage p0: input capture, history, counters ----
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      for (int i = 0; i < MAX_ORDER; i++) begin
        coef_q[i] <= '0;
        hist_q[i] <= '0;
      end
      order_q     <= '0;
      shift_q     <= '0;
      tap_q       <= '0;
      cnt_q       <= '0;
      res_p0      <= '0;
      sample_q    <= '0;
      warm_vld_p1 <= 1'b0;
      err_q       <= 1'b0;
    end else if (iEnable) begin
      warm_vld_p1 <= 1'b0;
      if (coef_wr) coef_q[iCoefAddr] <= $signed(iCoef);
      if (start_bad) err_q <= 1'b1;
      if (start_ok) begin
        order_q <= iOrder;
        shift_q <= iShift;
        tap_q   <= '0;
        cnt_q   <= '0;
        for (int i = 0; i < MAX_ORDER; i++) hist_q[i] <= '0;
      end
      if (push_en) begin
        for (int i = MAX_ORDER - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
        hist_q[0] <= push_val;
        sample_q  <= push_val;
        cnt_q     <= cnt_q + 1'b1;
      end
      // tap_q counts warm-up words, then MAC taps; it is zero on entry to each.
      if (accept && (state_q == ST_WARMUP)) begin
        warm_vld_p1 <= 1'b1;
        tap_q       <= last_tap ? 4'd0 : tap_q + 4'd1;
      end
      if (accept && (state_q == ST_RUN)) begin
        res_p0 <= $signed(iResidual);
        tap_q  <= '0;
      end
      if (state_q == ST_MAC) tap_q <= last_tap ? 4'd0 : tap_q + 4'd1;
    end
  end

endmodule

// File: doc/lpc_sample_reconstructor.md
LPC_SAMPLE_RECONSTRUCTOR -- requirements
Module: lpc_sample_reconstructor

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- MAX_ORDER, 12, maximum predictor order.
- BLOCK_SIZE, 4096, samples per block.
- COEF_WIDTH, 15, quantized coefficient width.
- SAMPLE_WIDTH, 16, reconstructed sample width.
- RES_WIDTH, 24, residual / warm-up input width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- iClock  in  1  single clock, rising edge.
- iReset  in  1  asynchronous, active-low reset.
- iEnable  in  1  clock enable; low freezes all state.
- iCoefWrite  in  1  coefficient write strobe.
- iCoefAddr  in  4  coefficient index.
- iCoef  in  COEF_WIDTH  signed coefficient.
- iStart  in  1  begin block; latches iOrder and iShift.
- iOrder  in  4  predictor order, 0..MAX_ORDER.
- iShift  in  5  quantization shift, 0..31.
- iValid  in  1  input word valid.
- iResidual  in  RES_WIDTH  signed warm-up sample or residual.
- oReady  out  1  input word accepted when iValid and oReady.
- oSample  out  SAMPLE_WIDTH  signed reconstructed sample.
- oValid  out  1  one-cycle pulse qualifying oSample.
- oDone  out  1  block complete; held until next iStart.
- oError  out  1  sticky; illegal order requested.
REQ-003 Clock and reset SHALL be fixed: one clock; reset is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have states IDLE, WARMUP, RUN, MAC, EMIT, DONE; all transitions are gated by iEnable=1.
REQ-005 Coefficient writes SHALL take effect only in IDLE or DONE; writes with iCoefAddr >= MAX_ORDER or in other states are ignored.
REQ-006 In IDLE or DONE, iStart SHALL:
- latch iOrder and iShift;
- clear the sample history and the sample counter;
- clear oDone;
- enter WARMUP (order > 0) or RUN (order 0).
REQ-007 If iStart arrives with iOrder > MAX_ORDER, the block SHALL set oError, stay in IDLE and not start. iStart in any other state SHALL be ignored.
REQ-008 In WARMUP, oReady=1; each of the first ORDER accepted words SHALL be emitted verbatim (low SAMPLE_WIDTH bits) on oSample with oValid on the next cycle, and pushed into history; then enter RUN.
REQ-009 In RUN, oReady=1. An accepted residual SHALL be latched; the block enters MAC, or EMIT directly when order=0.
REQ-010 MAC SHALL take exactly ORDER cycles with oReady=0, one tap per cycle: acc += coef[j]*hist[j], j=0..ORDER-1, where hist[0] is the most recent sample. The accumulator SHALL be signed 40-bit and cleared on MAC entry.
REQ-011 EMIT SHALL drive oSample = low SAMPLE_WIDTH bits of (residual + (acc >>> shift)) using an arithmetic shift and no saturation. oValid SHALL be high for that one cycle, the sample SHALL be pushed into history, and the counter SHALL be incremented.
REQ-012 Latency SHALL be ORDER+1 cycles from acceptance to oValid in RUN, and 1 cycle in WARMUP.
REQ-013 After output number BLOCK_SIZE, the block SHALL enter DONE: oDone=1, oReady=0, further iValid ignored.
REQ-014 When iEnable=0, all registers SHALL hold, oReady SHALL read 0, and oValid SHALL not assert.
REQ-015 There SHALL be no output backpressure; the downstream block must accept every oValid pulse.

Reset
REQ-016 Reset low SHALL immediately force: state=IDLE; oSample=0, oValid=0, oReady=0, oDone=0, oError=0; coefficients, history, accumulator and counter=0.
REQ-017 Reset asserted mid-block SHALL discard the block; no further oValid until a new iStart.

Structure
REQ-018 MAX_ORDER, the widths, BLOCK_SIZE and the FSM state encodings SHALL live in the shared FLAC parameter header used by the encoder blocks.
REQ-019 The multiply-accumulate datapath SHALL be one sub-module, lpc_mac (clear, enable, coef, sample -> 40-bit acc).

Verification
REQ-020 Order 0: residuals 5, -3 -> oSample 5, -3, each 1 cycle after acceptance.
REQ-021 Order 1, coef0=1, shift 0: inputs 100, 1, 1, 1 -> 100, 101, 102, 103; residual outputs 2 cycles after acceptance.
REQ-022 Order 2, coef0=2, coef1=-1, shift 0: inputs 10, 20, 0, 0 -> 10, 20, 30, 40.
REQ-023 Order 1, coef0=3, shift 1: warm-up 7, residual 0 -> 7, 10; warm-up -7, residual 0 -> -7, -11.
REQ-024 BLOCK_SIZE=8: after the 8th oValid, oDone=1 and oReady=0, and a 9th iValid produces no output. iStart with order 13 -> oError=1, state IDLE.
REQ-025 Reset low during MAC -> all outputs 0 within the same cycle, coefficients read 0, and no oValid until a new iStart.
